// File: rtl/video_timing.sv
// Raster timing generator: progressive 640x480@60 at one clock per pixel, or interlaced
// at two clocks per pixel with two fields per frame. Mode changes only at frame wrap.
module video_timing #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned VI_FRONT = 3,
    parameter int unsigned VI_SYNC  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        interlaced,
    output logic        display_next_pixel,
    output logic        display_next_line,
    output logic        display_next_frame,
    output logic        display_current_field,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        blank,
    output logic [10:0] h_count,
    output logic [9:0]  v_count
);

    localparam int unsigned HT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned VT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] HP_LAST     = 11'(HT - 1);
    localparam logic [10:0] HI_LAST     = 11'(2 * HT - 1);
    localparam logic [10:0] HP_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] HI_ACT      = 11'(2 * H_ACTIVE);
    localparam logic [10:0] HP_SYNC_BEG = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] HP_SYNC_END = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] HI_SYNC_BEG = 11'(2 * (H_ACTIVE + H_FRONT));
    localparam logic [10:0] HI_SYNC_END = 11'(2 * (H_ACTIVE + H_FRONT + H_SYNC));

    // Field 0 takes the odd extra line of an odd-length frame.
    localparam logic [9:0] VP_LAST     = 10'(VT - 1);
    localparam logic [9:0] VF0_LAST    = 10'((VT + 1) / 2 - 1);
    localparam logic [9:0] VF1_LAST    = 10'(VT / 2 - 1);
    localparam logic [9:0] VP_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] VI_ACT      = 10'(V_ACTIVE / 2);
    localparam logic [9:0] VP_SYNC_BEG = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VP_SYNC_END = 10'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [9:0] VI_SYNC_BEG = 10'(V_ACTIVE / 2 + VI_FRONT);
    localparam logic [9:0] VI_SYNC_END = 10'(V_ACTIVE / 2 + VI_FRONT + VI_SYNC);

    logic [10:0] h_q, h_d, h_last;
    logic [9:0]  v_q, v_d, v_last;
    logic        mode_q, mode_d;
    logic        field_q, field_d;
    logic        h_wrap, frame_wrap;

    logic        h_active, v_active;
    logic        pixel_d, line_d, frame_d, hsync_d, vsync_d;

    // Next-state counters; wrap limits follow the mode/field currently being scanned.
    always_comb begin
        h_last = mode_q ? HI_LAST : HP_LAST;
        if (!mode_q) begin
            v_last = VP_LAST;
        end else if (field_q) begin
            v_last = VF1_LAST;
        end else begin
            v_last = VF0_LAST;
        end

        h_wrap     = (h_q == h_last);
        frame_wrap = h_wrap && (v_q == v_last);

        h_d = h_wrap ? 11'd0 : h_q + 11'd1;
        if (frame_wrap) begin
            v_d = 10'd0;
        end else if (h_wrap) begin
            v_d = v_q + 10'd1;
        end else begin
            v_d = v_q;
        end

        mode_d  = frame_wrap ? interlaced : mode_q;
        // First interlaced field after a progressive frame is always field 0.
        field_d = frame_wrap ? (interlaced && mode_q && !field_q) : field_q;
    end

    // Decode from next-state values so registered strobes line up with the counts.
    always_comb begin
        if (mode_d) begin
            h_active = (h_d < HI_ACT);
            hsync_d  = !((h_d >= HI_SYNC_BEG) && (h_d < HI_SYNC_END));
            v_active = (v_d < VI_ACT);
            vsync_d  = !((v_d >= VI_SYNC_BEG) && (v_d < VI_SYNC_END));
        end else begin
            h_active = (h_d < HP_ACT);
            hsync_d  = !((h_d >= HP_SYNC_BEG) && (h_d < HP_SYNC_END));
            v_active = (v_d < VP_ACT);
            vsync_d  = !((v_d >= VP_SYNC_BEG) && (v_d < VP_SYNC_END));
        end
        pixel_d = h_active && v_active;
        line_d  = (h_d == 11'd0);
        frame_d = line_d && (v_d == 10'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q                <= HP_LAST;
            v_q                <= VP_LAST;
            mode_q             <= 1'b0;
            field_q            <= 1'b0;
            display_next_pixel <= 1'b0;
            display_next_line  <= 1'b0;
            display_next_frame <= 1'b0;
            hsync_n            <= 1'b1;
            vsync_n            <= 1'b1;
            blank              <= 1'b1;
        end else begin
            h_q                <= h_d;
            v_q                <= v_d;
            mode_q             <= mode_d;
            field_q            <= field_d;
            display_next_pixel <= pixel_d;
            display_next_line  <= line_d;
            display_next_frame <= frame_d;
            hsync_n            <= hsync_d;
            vsync_n            <= vsync_d;
            blank              <= !pixel_d;
        end
    end

    assign h_count               = h_q;
    assign v_count               = v_q;
    assign display_current_field = field_q;

endmodule

// File: doc/video_timing.md
# video_timing

Raster timing generator that drives the display-side strobes (`display_next_pixel`, `display_next_line`, `display_next_frame`, `display_current_field`) consumed by the composer, plus sync/blank for the output encoder. It supports progressive 640x480@60 at the 25 MHz system clock (one pixel per clock) and a double-rate interlaced mode (two clocks per pixel, two fields per frame). Mode changes take effect only on frame boundaries.

## Interface
- `H_ACTIVE`, 640: active pixels per line (progressive clocks).
- `H_FRONT`, 16 / `H_SYNC`, 96 / `H_BACK`, 48: horizontal porches/sync, progressive clocks; H_TOTAL = 800.
- `V_ACTIVE`, 480 / `V_FRONT`, 10 / `V_SYNC`, 2 / `V_BACK`, 33: progressive lines; V_TOTAL = 525.
- `VI_FRONT`, 3 / `VI_SYNC`, 3: interlaced per-field front porch/sync lines; active = V_ACTIVE/2, back porch fills the field (17 lines field 0, 16 lines field 1).
- `clk` in 1: system clock. One clock domain; reset is synchronous and active-high.
- `rst` in 1: synchronous active-high reset.
- `interlaced` in 1: mode request, sampled only at frame wrap.
- `display_next_pixel` out 1: high each clock an active pixel slot is presented.
- `display_next_line` out 1: one-clock pulse at the start of every line (h_count = 0), including blanking lines.
- `display_next_frame` out 1: one-clock pulse at h_count = 0, v_count = 0; coincides with `display_next_line`.
- `display_current_field` out 1: field being scanned (0 even/first, 1 odd/second); always 0 in progressive.
- `hsync_n`, `vsync_n` out 1: active-low sync.
- `blank` out 1: high outside the active area.
- `h_count` out 11: horizontal position in clocks. `v_count` out 10: line within frame/field.

## Operation
- Internal latched mode `mode_i`. Line length HT = 800 (progressive) or 1600 (interlaced); every horizontal parameter is doubled in interlaced mode.
- h_count runs 0..HT-1 and wraps to 0. On wrap, v_count increments, or wraps at frame/field end.
- Frame/field end:
  - Progressive: after v_count = 524.
  - Interlaced: after 262 in field 0 (263 lines) and 261 in field 1 (262 lines).
- At frame wrap:
  - `mode_i` <= `interlaced`.
  - Field: progressive forces 0; interlaced toggles, or sets 0 if the previous frame was progressive.
- Decode, relative to the current (h, v), with scaled parameters:
  - hactive = h < H_ACTIVE·k (k = 1 or 2).
  - hsync_n = 0 for h in [(H_ACTIVE+H_FRONT)·k, (H_ACTIVE+H_FRONT+H_SYNC)·k).
  - vactive = v < 480 (progressive) or v < 240 (interlaced).
  - vsync_n = 0 for v in [490, 492) progressive or [243, 246) interlaced.
  - `display_next_pixel` = hactive && vactive. It is asserted every clock in both modes, so interlaced gives 1280 pulses per active line; the composer halves the increment.
  - `blank` = !(hactive && vactive).
- All outputs are registered together with the counters. Each output describes the h/v/field values visible in the same cycle; there is no skew between strobes and counts.
- Reset state:
  - Counters preset to h = HT-1 and v = last line of frame with mode progressive, so the first clock after `rst` falls produces the frame wrap.
  - Output reset values: all pulses 0, `hsync_n` = `vsync_n` = 1, `blank` = 1, `display_current_field` = 0, `h_count` = 799, `v_count` = 524.

## Timing
- First cycle after `rst` deasserts:
  - `display_next_frame` = `display_next_line` = 1.
  - h = 0, v = 0, field 0.
  - `display_next_pixel` = 1, `blank` = 0.
- Mode sampled at the frame-wrap edge. `interlaced` toggling mid-frame has no effect until the next `display_next_frame`. The frame is never truncated.
- `rst` mid-line: the next clock shows reset values regardless of position; the sequence restarts as above.
- `display_next_line` period is exactly HT. `display_next_frame` period:
  - Progressive: 420000 clocks.
  - Interlaced: alternates 420800 (field 0) and 419200 (field 1).
- `display_current_field` changes in the same cycle that `display_next_frame` is high and is held through the field.
- No latency from counter to outputs; registered decode uses next-state values.

## Test plan
- Progressive, from reset:
  - `display_next_line` every 800 clocks and `display_next_frame` every 420000.
  - 640 `display_next_pixel` clocks per line on lines 0..479, none on 480..524.
- Progressive sync:
  - `hsync_n` low exactly for h = 656..751 (96 clocks).
  - `vsync_n` low for lines 490..491.
  - `blank` high at h = 640 and at v = 480.
- Interlaced (`interlaced` = 1 before the reset release frame boundary):
  - Line = 1600 clocks and hsync low for h = 1312..1503.
  - Fields of 263 and 262 lines with `display_current_field` 0, 1, 0, …
  - `vsync_n` low on lines 243..245.
- Mode switch: raise `interlaced` at v = 100 of a progressive frame.
  - Progressive timing continues to v = 524.
  - Interlaced timing begins at the next `display_next_frame` with field 0.
- Reset mid-operation: assert `rst` one clock at h = 400, v = 200.
  - Next cycle shows `h_count` = 799, `v_count` = 524, `hsync_n` = 1, `blank` = 1.
  - Following cycle shows `display_next_frame` = 1, h = 0, v = 0.
- Coincidence: at every frame wrap `display_next_frame` and `display_next_line` are both high for exactly one clock, and never at any other h = 0 only `display_next_frame`.
